spdif_subframe_sequencer: RTL and testbench
===========================================

SPDIF_SUBFRAME_SEQUENCER -- requirements
Module: spdif_subframe_sequencer

Interface
REQ-001 SHALL have parameters: none; constants come from spdif_pkg.
REQ-002 clk128  input  1  bit-rate clock, 128x sample rate; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 i_valid  input  1  stereo sample offered.
REQ-005 i_ready  output  1  sample holding register empty.
REQ-006 i_left, i_right  input  24 each  audio words; aux bits are in the LSBs.
REQ-007 i_v, i_u, i_c  input  2 each  validity, user and channel-status bits; bit0 is left, bit1 is right.
REQ-008 o_valid  output  1  nibble offered to the BMC encoder.
REQ-009 o_ready  input  1  BMC encoder accepts a nibble.
REQ-010 o_data  output  4  toggle-coded nibble, MSB sent first.
REQ-011 o_frame  output  8  frame index 0..191 of the current subframe.
REQ-012 o_block_start  output  1  one-cycle pulse when the frame-0 left nibble 0 is accepted.

Function
REQ-013 A subframe SHALL be 16 nibbles (64 half-cells): nibbles 0-1 are the preamble, and nibbles 2-15 carry data time slots 4-31, two slots per nibble.
REQ-014 Preamble nibbles SHALL be: B = 1001,1100; M = 1001,0011; W = 1001,0110.
REQ-015 Preamble selection SHALL be: B for left of frame 0, M for left of frames 1-191, W for every right subframe.
REQ-016 A data nibble for slots k, k+1 SHALL be {1, d[k], 1, d[k+1]}.
REQ-017 Slot order SHALL be: slots 4-27 = audio word LSB first, 28 = V, 29 = U, 30 = C, 31 = P.
REQ-018 P SHALL make slots 4-31 even parity.
REQ-019 A nibble transfers only on a cycle with o_valid && o_ready; o_data and o_valid SHALL be held stable until that transfer.
REQ-020 FSM states SHALL be IDLE, LEFT and RIGHT, with a 4-bit nibble counter.
REQ-021 IDLE -> LEFT when the holding register is full; the sample moves to the active register on that transition.
REQ-022 LEFT -> RIGHT when nibble 15 is accepted.
REQ-023 RIGHT -> LEFT when nibble 15 is accepted and the holding register is full.
REQ-024 Otherwise RIGHT -> IDLE, or the behaviour in REQ-032 applies when that option is compiled in.
REQ-025 o_frame SHALL increment when right nibble 15 is accepted, wrapping 191 -> 0.
REQ-026 i_ready SHALL be !hold_full.
REQ-027 An input handshake and a transfer out of the holding register in the same cycle SHALL leave the register full with the new sample.
REQ-028 o_valid SHALL be 0 in IDLE and 1 in LEFT and RIGHT.
REQ-029 The first nibble SHALL be valid one cycle after entry to LEFT.
REQ-030 The parity and nibble mux SHALL be registered so that o_data changes only after an accept or a state entry.

Reset
REQ-031 While reset_n = 0, the block SHALL hold: state IDLE, counter 0, o_frame 0, o_valid 0, o_data 0, o_block_start 0, holding register empty (i_ready 1), active register 0. Reset mid-subframe SHALL abandon the subframe; the next subframe restarts at frame 0 with preamble B.

Configuration
REQ-032 SPDIF_UNDERRUN_MUTE_EN defined: at RIGHT nibble 15 with the holding register empty, the FSM SHALL go to LEFT with a zero sample and V = 1 on both channels. The stream never stops after the first sample.
REQ-033 SPDIF_UNDERRUN_MUTE_EN undefined: the FSM SHALL go to IDLE, o_valid drops, and o_frame is retained. The next sample resumes at the retained frame index.

Structure
REQ-034 spdif_pkg SHALL hold: preamble constants, SUBFRAME_NIBBLES = 16, FRAMES_PER_BLOCK = 192, the state enum and the sample-record typedef.
REQ-035 One sub-module spdif_subframe_builder (combinational) SHALL assemble the 28-slot word with parity and select nibble n; the FSM and registers stay in the top level.

Verification
REQ-036 Reset, then one sample L = 0x000001, R = 0x800000, V/U/C = 0, with o_ready tied 1 -> left nibbles 1001,1100,1110,1010 and so on; left P = 1, right P = 1; o_block_start pulses once.
REQ-037 Continuous samples for 193 frames -> preamble B at frames 0 and 192 only, M otherwise; o_frame wraps 191 -> 0.
REQ-038 o_ready toggled randomly -> o_data stable while stalled; 16 accepts per subframe; no nibble lost or duplicated.
REQ-039 Input gap after frame 5 (macro undefined) -> o_valid 0 after right nibble 15; the next sample resumes with preamble M at frame 6.
REQ-040 Same gap with SPDIF_UNDERRUN_MUTE_EN defined -> uninterrupted subframes with zero audio and V = 1 on both channels.
REQ-041 reset_n pulsed at left nibble 7 -> all outputs at reset values; the next sample starts at frame 0 with preamble B.

Source files
------------

// File: rtl/spdif_pkg.sv
// Shared constants and types for the S/PDIF subframe sequencer.
package spdif_pkg;

    localparam int unsigned SUBFRAME_NIBBLES = 16;
    localparam int unsigned FRAMES_PER_BLOCK = 192;

    // Toggle-coded preambles, first nibble in the upper half.
    localparam logic [7:0] PRE_B = 8'b1001_1100;
    localparam logic [7:0] PRE_M = 8'b1001_0011;
    localparam logic [7:0] PRE_W = 8'b1001_0110;

    localparam logic [3:0] LAST_NIBBLE = 4'(SUBFRAME_NIBBLES - 1);
    localparam logic [7:0] LAST_FRAME  = 8'(FRAMES_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } state_e;

    typedef struct packed {
        logic [23:0] left;
        logic [23:0] right;
        logic [1:0]  v;
        logic [1:0]  u;
        logic [1:0]  c;
    } sample_t;

    localparam sample_t MUTE_SAMPLE = '{left: '0, right: '0, v: 2'b11, u: '0, c: '0};

endpackage

// File: rtl/spdif_subframe_builder.sv
// Combinational subframe assembler: builds the 28-slot word with even parity
// and returns toggle-coded nibble idx (preamble for nibbles 0-1).
module spdif_subframe_builder
    import spdif_pkg::*;
(
    input  logic [23:0] audio,
    input  logic        v,
    input  logic        u,
    input  logic        c,
    input  logic        right,
    input  logic        first_frame,
    input  logic [3:0]  idx,
    output logic [3:0]  nibble
);

    logic [27:0] word;
    logic [7:0]  pre;
    logic [4:0]  bit_idx;
    logic [1:0]  pair;

    always_comb begin
        word     = {1'b0, c, u, v, audio};
        word[27] = ^word[26:0];
        pre      = right ? PRE_W : (first_frame ? PRE_B : PRE_M);
        // Nibble n carries slots 2n and 2n+1, i.e. word bits 2n-4 and 2n-3.
        bit_idx  = {idx, 1'b0} - 5'd4;
        pair     = 2'(word >> bit_idx);
        case (idx)
            4'd0:    nibble = pre[7:4];
            4'd1:    nibble = pre[3:0];
            default: nibble = {1'b1, pair[0], 1'b1, pair[1]};
        endcase
    end

endmodule

// File: rtl/spdif_subframe_sequencer.sv
// S/PDIF subframe sequencer: stereo sample in, toggle-coded nibbles out.
// Define SPDIF_UNDERRUN_MUTE_EN to replace input underruns with muted frames.
module spdif_subframe_sequencer
    import spdif_pkg::*;
(
    input  logic        clk128,
    input  logic        reset_n,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [23:0] i_left,
    input  logic [23:0] i_right,
    input  logic [1:0]  i_v,
    input  logic [1:0]  i_u,
    input  logic [1:0]  i_c,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [3:0]  o_data,
    output logic [7:0]  o_frame,
    output logic        o_block_start
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  frame_q, frame_d;
    sample_t     hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    sample_t     act_q, act_d;
    logic [3:0]  data_q, data_d;
    logic        accept, last_nibble, load_act, side_right, data_en;
    logic [23:0] audio_sel;
    logic [3:0]  nibble;

    assign i_ready       = !hold_full_q;
    assign o_valid       = (state_q != IDLE);
    assign o_data        = data_q;
    assign o_frame       = frame_q;
    assign o_block_start = accept && (state_q == LEFT) && (cnt_q == 4'd0) && (frame_q == 8'd0);

    always_comb begin
        accept      = o_valid && o_ready;
        last_nibble = accept && (cnt_q == LAST_NIBBLE);
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        act_d       = act_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load_act    = 1'b0;
        if (accept) cnt_d = cnt_q + 4'd1;
        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d  = LEFT;
                    load_act = 1'b1;
                    cnt_d    = '0;
                end
            end
            LEFT: begin
                if (last_nibble) state_d = RIGHT;
            end
            RIGHT: begin
                if (last_nibble) begin
                    frame_d = (frame_q == LAST_FRAME) ? 8'd0 : frame_q + 8'd1;
                    if (hold_full_q) begin
                        state_d  = LEFT;
                        load_act = 1'b1;
                    end else begin
`ifdef SPDIF_UNDERRUN_MUTE_EN
                        state_d = LEFT;
                        act_d   = MUTE_SAMPLE;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_act) begin
            act_d       = hold_q;
            hold_full_d = 1'b0;
        end
        // Taking a new sample last lets a simultaneous move-out leave the register full.
        if (i_valid && i_ready) begin
            hold_d      = '{left: i_left, right: i_right, v: i_v, u: i_u, c: i_c};
            hold_full_d = 1'b1;
        end
    end

    // The nibble register is fed from next-state values so o_data lines up with the counter.
    always_comb begin
        side_right = (state_d == RIGHT);
        audio_sel  = side_right ? act_d.right : act_d.left;
        data_en    = (state_q == IDLE) || accept;
        data_d     = (state_d == IDLE) ? 4'd0 : nibble;
    end

    spdif_subframe_builder u_builder (
        .audio       (audio_sel),
        .v           (act_d.v[side_right]),
        .u           (act_d.u[side_right]),
        .c           (act_d.c[side_right]),
        .right       (side_right),
        .first_frame (frame_d == 8'd0),
        .idx         (cnt_d),
        .nibble      (nibble)
    );

    always_ff @(posedge clk128 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            act_q       <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            act_q       <= act_d;
            if (data_en) data_q <= data_d;
        end
    end

endmodule

// File: tb/tb_spdif_subframe_sequencer.sv
// Directed self-checking bench for spdif_subframe_sequencer (honours SPDIF_UNDERRUN_MUTE_EN).
module tb_spdif_subframe_sequencer;

    logic        clk128 = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_valid;
    logic        i_ready;
    logic [23:0] i_left, i_right;
    logic [1:0]  i_v, i_u, i_c;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [3:0]  o_data;
    logic [7:0]  o_frame;
    logic        o_block_start;

    int total = 0;
    int bad   = 0;
    int feed_left = 0;
    int fed = 0;
    bit rand_rdy = 1'b0;

    always #5 clk128 = ~clk128;

    spdif_subframe_sequencer dut (
        .clk128        (clk128),
        .reset_n       (reset_n),
        .i_valid       (i_valid),
        .i_ready       (i_ready),
        .i_left        (i_left),
        .i_right       (i_right),
        .i_v           (i_v),
        .i_u           (i_u),
        .i_c           (i_c),
        .o_valid       (o_valid),
        .o_ready       (o_ready),
        .o_data        (o_data),
        .o_frame       (o_frame),
        .o_block_start (o_block_start)
    );

    // Sample 0 is L=0x000001, R=0x800000, V/U/C=0.
    function automatic logic [23:0] gen_l(input int n);
        return 24'(n * 32'h000A5C31 + 1);
    endfunction

    function automatic logic [23:0] gen_r(input int n);
        return 24'(n * 32'h0003F1D7) ^ 24'h800000;
    endfunction

    function automatic logic [5:0] gen_vuc(input int n);
        return 6'(n * 11);
    endfunction

    // Expected 64 half-cells of a subframe; n < 0 selects the muted sample.
    function automatic logic [63:0] exp_for(input int n, input bit right, input int frame);
        logic [23:0] a;
        logic [5:0]  vuc;
        logic [7:0]  pre;
        logic        v, u, c, p, d;
        logic [63:0] r;
        if (n < 0) begin
            a   = '0;
            vuc = 6'b00_00_11;
        end else begin
            a   = right ? gen_r(n) : gen_l(n);
            vuc = gen_vuc(n);
        end
        v   = right ? vuc[1] : vuc[0];
        u   = right ? vuc[3] : vuc[2];
        c   = right ? vuc[5] : vuc[4];
        p   = ^{a, v, u, c};
        pre = right ? 8'b1001_0110 : ((frame == 0) ? 8'b1001_1100 : 8'b1001_0011);
        r   = '0;
        r[63:56] = pre;
        for (int k = 4; k < 32; k++) begin
            if (k < 28)       d = a[k-4];
            else if (k == 28) d = v;
            else if (k == 29) d = u;
            else if (k == 30) d = c;
            else              d = p;
            r[63-2*k] = 1'b1;
            r[62-2*k] = d;
        end
        return r;
    endfunction

    initial begin
        i_valid = 1'b0;
        i_left  = '0;
        i_right = '0;
        i_v = '0;
        i_u = '0;
        i_c = '0;
        forever begin
            @(negedge clk128);
            if (feed_left > 0 && i_ready === 1'b1) begin
                i_left  = gen_l(fed);
                i_right = gen_r(fed);
                {i_c, i_u, i_v} = gen_vuc(fed);
                i_valid = 1'b1;
                fed++;
                feed_left--;
            end else begin
                i_valid = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    // Collects n accepted nibbles; reports block-start pulses and stall-time data changes.
    task automatic get_nibs(input int n, output logic [63:0] bits, output logic [7:0] frm,
                            output int bs, output int stab, output bit tmo);
        int k, cyc;
        logic [3:0] prev;
        bit stall;
        bits = '0; frm = '0; bs = 0; stab = 0; k = 0; cyc = 0; stall = 1'b0; prev = '0;
        while (k < n && cyc < 4000) begin
            @(negedge clk128);
            cyc++;
            if (rand_rdy) o_ready = 1'($urandom_range(0, 1));
            #1;
            if (stall && o_data !== prev) stab++;
            if (o_block_start === 1'b1) bs++;
            if (o_valid === 1'b1 && o_ready === 1'b1) begin
                if (k == 0) frm = o_frame;
                bits[63-4*k -: 4] = o_data;
                k++;
                stall = 1'b0;
            end else begin
                stall = (o_valid === 1'b1);
                prev  = o_data;
            end
        end
        tmo = (k < n);
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        feed_left = 0;
        rand_rdy  = 1'b0;
        o_ready   = 1'b1;
        repeat (3) @(negedge clk128);
        reset_n = 1'b1;
        fed = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        feed_left = 0;
        repeat (2) @(negedge clk128);
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
        total++; if (o_data !== 4'd0) begin bad++; $display("FAIL reset_o_data: got %h want 0", o_data); end
        total++; if (o_frame !== 8'd0) begin bad++; $display("FAIL reset_o_frame: got %0d want 0", o_frame); end
        total++; if (o_block_start !== 1'b0) begin bad++; $display("FAIL reset_block_start: got %b want 0", o_block_start); end
        total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL reset_i_ready: got %b want 1", i_ready); end
    endtask

    task automatic test_single_sample();
        logic [63:0] bl, br;
        logic [7:0] fl, fr;
        int bs1, bs2, st;
        bit t1, t2;
        apply_reset();
        feed_left = 1;
        get_nibs(16, bl, fl, bs1, st, t1);
        get_nibs(16, br, fr, bs2, st, t2);
        total++; if (t1 || t2) begin bad++; $display("FAIL single_timeout: got %b%b want 00", t1, t2); end
        total++; if (bl[63:48] !== 16'b1001_1100_1110_1010) begin bad++; $display("FAIL single_left_head: got %b want 1001110011101010", bl[63:48]); end
        total++; if (bl[3:0] !== 4'b1011) begin bad++; $display("FAIL single_left_parity: got %b want 1011", bl[3:0]); end
        total++; if (bl !== exp_for(0, 1'b0, 0)) begin bad++; $display("FAIL single_left_full: got %h want %h", bl, exp_for(0, 1'b0, 0)); end
        total++; if (br[63:56] !== 8'b1001_0110) begin bad++; $display("FAIL single_right_pre: got %b want 10010110", br[63:56]); end
        total++; if (br[11:8] !== 4'b1011) begin bad++; $display("FAIL single_right_msb: got %b want 1011", br[11:8]); end
        total++; if (br[3:0] !== 4'b1011) begin bad++; $display("FAIL single_right_parity: got %b want 1011", br[3:0]); end
        total++; if (fl !== 8'd0) begin bad++; $display("FAIL single_frame: got %0d want 0", fl); end
        total++; if (bs1 + bs2 !== 1) begin bad++; $display("FAIL single_block_start: got %0d want 1", bs1 + bs2); end
        @(negedge clk128);
        #1;
`ifdef SPDIF_UNDERRUN_MUTE_EN
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL single_after_valid: got %b want 1", o_valid); end
`else
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL single_after_valid: got %b want 0", o_valid); end
`endif
        total++; if (o_frame !== 8'd1) begin bad++; $display("FAIL single_after_frame: got %0d want 1", o_frame); end
    endtask

    task automatic test_wrap();
        logic [63:0] bl, br;
        logic [7:0] fl, fr;
        int bs1, bs2, st, bs_sum;
        bit t1, t2;
        apply_reset();
        feed_left = 193;
        bs_sum = 0;
        for (int f = 0; f < 193; f++) begin
            get_nibs(16, bl, fl, bs1, st, t1);
            get_nibs(16, br, fr, bs2, st, t2);
            bs_sum += bs1 + bs2;
            total++;
            if (t1 || t2) begin
                bad++;
                $display("FAIL wrap_timeout: frame %0d got timeout want none", f);
                break;
            end
            total++; if (fl !== 8'(f % 192)) begin bad++; $display("FAIL wrap_frame: got %0d want %0d", fl, f % 192); end
            total++; if (bl !== exp_for(f, 1'b0, f % 192)) begin bad++; $display("FAIL wrap_left f%0d: got %h want %h", f, bl, exp_for(f, 1'b0, f % 192)); end
            total++; if (br !== exp_for(f, 1'b1, f % 192)) begin bad++; $display("FAIL wrap_right f%0d: got %h want %h", f, br, exp_for(f, 1'b1, f % 192)); end
        end
        total++; if (bs_sum !== 2) begin bad++; $display("FAIL wrap_block_starts: got %0d want 2", bs_sum); end
    endtask

    task automatic test_stall();
        logic [63:0] bl, br;
        logic [7:0] fl, fr;
        int bs1, bs2, st1, st2;
        bit t1, t2;
        apply_reset();
        feed_left = 4;
        rand_rdy = 1'b1;
        for (int f = 0; f < 4; f++) begin
            get_nibs(16, bl, fl, bs1, st1, t1);
            get_nibs(16, br, fr, bs2, st2, t2);
            total++; if (t1 || t2) begin bad++; $display("FAIL stall_timeout: frame %0d got timeout want none", f); end
            total++; if (st1 + st2 !== 0) begin bad++; $display("FAIL stall_stable: frame %0d got %0d changes want 0", f, st1 + st2); end
            total++; if (bl !== exp_for(f, 1'b0, f)) begin bad++; $display("FAIL stall_left f%0d: got %h want %h", f, bl, exp_for(f, 1'b0, f)); end
            total++; if (br !== exp_for(f, 1'b1, f)) begin bad++; $display("FAIL stall_right f%0d: got %h want %h", f, br, exp_for(f, 1'b1, f)); end
        end
        rand_rdy = 1'b0;
        o_ready  = 1'b1;
    endtask

    task automatic test_gap();
        logic [63:0] bl, br;
        logic [7:0] fl, fr;
        int bs1, bs2, st;
        bit t1, t2;
        apply_reset();
        feed_left = 6;
        for (int f = 0; f < 6; f++) begin
            get_nibs(16, bl, fl, bs1, st, t1);
            get_nibs(16, br, fr, bs2, st, t2);
            total++; if (t1 || t2 || bl !== exp_for(f, 1'b0, f) || br !== exp_for(f, 1'b1, f)) begin
                bad++; $display("FAIL gap_pre f%0d: got %h %h want %h %h", f, bl, br, exp_for(f, 1'b0, f), exp_for(f, 1'b1, f));
            end
        end
`ifdef SPDIF_UNDERRUN_MUTE_EN
        for (int f = 6; f < 10; f++) begin
            if (f == 8) feed_left = 1;
            get_nibs(16, bl, fl, bs1, st, t1);
            get_nibs(16, br, fr, bs2, st, t2);
            total++; if (t1 || t2) begin bad++; $display("FAIL gap_mute_timeout: frame %0d got timeout want none", f); end
            total++; if (fl !== 8'(f)) begin bad++; $display("FAIL gap_mute_frame: got %0d want %0d", fl, f); end
            total++; if (bl !== exp_for((f < 9) ? -1 : 6, 1'b0, f)) begin bad++; $display("FAIL gap_mute_left f%0d: got %h want %h", f, bl, exp_for((f < 9) ? -1 : 6, 1'b0, f)); end
            total++; if (br !== exp_for((f < 9) ? -1 : 6, 1'b1, f)) begin bad++; $display("FAIL gap_mute_right f%0d: got %h want %h", f, br, exp_for((f < 9) ? -1 : 6, 1'b1, f)); end
        end
`else
        @(negedge clk128);
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL gap_valid_drop: got %b want 0", o_valid); end
        total++; if (o_frame !== 8'd6) begin bad++; $display("FAIL gap_frame_kept: got %0d want 6", o_frame); end
        repeat (10) @(negedge clk128);
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL gap_valid_idle: got %b want 0", o_valid); end
        feed_left = 1;
        get_nibs(16, bl, fl, bs1, st, t1);
        get_nibs(16, br, fr, bs2, st, t2);
        total++; if (t1 || t2) begin bad++; $display("FAIL gap_resume_timeout: got %b%b want 00", t1, t2); end
        total++; if (fl !== 8'd6) begin bad++; $display("FAIL gap_resume_frame: got %0d want 6", fl); end
        total++; if (bl !== exp_for(6, 1'b0, 6)) begin bad++; $display("FAIL gap_resume_left: got %h want %h", bl, exp_for(6, 1'b0, 6)); end
        total++; if (br !== exp_for(6, 1'b1, 6)) begin bad++; $display("FAIL gap_resume_right: got %h want %h", br, exp_for(6, 1'b1, 6)); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [63:0] bl, br;
        logic [7:0] fl, fr;
        int bs1, bs2, st;
        bit t1, t2;
        apply_reset();
        feed_left = 2;
        get_nibs(8, bl, fl, bs1, st, t1);
        total++; if (t1) begin bad++; $display("FAIL mid_timeout: got timeout want none"); end
        reset_n = 1'b0;
        feed_left = 0;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_o_valid: got %b want 0", o_valid); end
        total++; if (o_data !== 4'd0) begin bad++; $display("FAIL mid_o_data: got %h want 0", o_data); end
        total++; if (o_frame !== 8'd0) begin bad++; $display("FAIL mid_o_frame: got %0d want 0", o_frame); end
        total++; if (o_block_start !== 1'b0) begin bad++; $display("FAIL mid_block_start: got %b want 0", o_block_start); end
        total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL mid_i_ready: got %b want 1", i_ready); end
        repeat (2) @(negedge clk128);
        reset_n = 1'b1;
        fed = 0;
        feed_left = 1;
        get_nibs(16, bl, fl, bs1, st, t1);
        get_nibs(16, br, fr, bs2, st, t2);
        total++; if (t1 || t2) begin bad++; $display("FAIL mid_restart_timeout: got %b%b want 00", t1, t2); end
        total++; if (fl !== 8'd0) begin bad++; $display("FAIL mid_restart_frame: got %0d want 0", fl); end
        total++; if (bl !== exp_for(0, 1'b0, 0)) begin bad++; $display("FAIL mid_restart_left: got %h want %h", bl, exp_for(0, 1'b0, 0)); end
        total++; if (br !== exp_for(0, 1'b1, 0)) begin bad++; $display("FAIL mid_restart_right: got %h want %h", br, exp_for(0, 1'b1, 0)); end
        total++; if (bs1 !== 1) begin bad++; $display("FAIL mid_restart_block_start: got %0d want 1", bs1); end
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_wrap();
        test_stall();
        test_gap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
